vote4_majority: RTL and testbench

- Four-input threshold voter. It samples single-bit inputs a, b, c, d on every clock.
- Registered output s asserts when the number of high inputs meets a configurable threshold (default: strict majority, 3 of 4).
- Also exports the registered population count.
- Used as a small voting/decision leaf cell wherever four redundant or independent flags must be combined into one decision.

---
 rtl/vote_pkg.sv | 17 +
 rtl/popcount4_comb.sv | 11 +
 rtl/vote4_majority.sv | 71 +++++++
 tb/tb_vote4_majority.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared sizing and the popcount helper for the four-input voter.
package vote_pkg;

  localparam int unsigned VOTE_W = 4;
  localparam int unsigned CNT_W  = 3;

  // Two-level adder tree: two pair sums, then one final sum. The result
  // tops out at 4 = 3'b100, so CNT_W bits never overflow.
  function automatic logic [CNT_W-1:0] popcount4(input logic [VOTE_W-1:0] votes);
    logic [1:0] lo_sum;
    logic [1:0] hi_sum;
    lo_sum = {1'b0, votes[0]} + {1'b0, votes[1]};
    hi_sum = {1'b0, votes[2]} + {1'b0, votes[3]};
    return {1'b0, lo_sum} + {1'b0, hi_sum};
  endfunction

endpackage

// File: rtl/popcount4_comb.sv
// Combinational population count of the four votes.
module popcount4_comb
  import vote_pkg::*;
(
  input  logic [VOTE_W-1:0] votes,
  output logic [CNT_W-1:0]  count
);

  assign count = popcount4(votes);

endmodule

// File: rtl/vote4_majority.sv
// Four-input threshold voter with registered decision, count and all/none flags.
module vote4_majority
  import vote_pkg::*;
#(
  parameter int unsigned THRESHOLD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       s,
  output logic [2:0] cnt,
  output logic       all_one,
  output logic       none_one
);

  // A threshold above the voter count could never be met; refuse to build.
  generate
    if (THRESHOLD > VOTE_W) begin : g_bad_threshold
      $error("vote4_majority: THRESHOLD must be in 0..4");
    end
  endgenerate

  localparam logic [CNT_W-1:0] THR = THRESHOLD[CNT_W-1:0];

  logic [VOTE_W-1:0] votes;
  logic [CNT_W-1:0]  cnt_c;
  logic              s_c;
  logic              all_c;
  logic              none_c;

  logic              s_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              all_p0;
  logic              none_p0;

  assign votes = {a, b, c, d};

  popcount4_comb u_popcount (
    .votes (votes),
    .count (cnt_c)
  );

  assign s_c    = (cnt_c >= THR);
  assign all_c  = &votes;
  assign none_c = ~(|votes);

  // Stage p0: register decision, count and flags; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p0    <= 1'b0;
      cnt_p0  <= '0;
      all_p0  <= 1'b0;
      none_p0 <= 1'b0;
    end else if (en) begin
      s_p0    <= s_c;
      cnt_p0  <= cnt_c;
      all_p0  <= all_c;
      none_p0 <= none_c;
    end
  end

  assign s        = s_p0;
  assign cnt      = cnt_p0;
  assign all_one  = all_p0;
  assign none_one = none_p0;

endmodule

// File: tb/tb_vote4_majority.sv
// Scoreboard bench for vote4_majority: one instance per THRESHOLD 0..4 on shared inputs.
module tb_vote4_majority;

  typedef struct packed {
    logic [4:0] s_vec;
    logic [2:0] cnt;
    logic       all_one;
    logic       none_one;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

  logic       s_t    [5];
  logic [2:0] cnt_t  [5];
  logic       all_t  [5];
  logic       none_t [5];

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  exp_t model;
  bit   sampled = 1'b0;

  always #5 clk = ~clk;

  for (genvar t = 0; t < 5; t++) begin : g_dut
    vote4_majority #(.THRESHOLD(t)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .s        (s_t[t]),
      .cnt      (cnt_t[t]),
      .all_one  (all_t[t]),
      .none_one (none_t[t])
    );
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus (v = {a,b,c,d}), push the expectation, then
  // pop and compare after the edge.
  task automatic step(input logic r, input logic e, input logic [3:0] v);
    int   n;
    exp_t exp;
    @(negedge clk);
    rst = r; en = e;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    n = int'(v[3]) + int'(v[2]) + int'(v[1]) + int'(v[0]);
    if (r) begin
      model = '0;
    end else if (e) begin
      model.cnt      = 3'(n);
      model.all_one  = (n == 4);
      model.none_one = (n == 0);
      for (int t = 0; t < 5; t++) model.s_vec[t] = (n >= t);
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 0, 1);
    end else begin
      exp = sb.pop_front();
      for (int t = 0; t < 5; t++) begin
        check_eq($sformatf("s_thr%0d_v%b", t, v), int'(s_t[t]), int'(exp.s_vec[t]));
        check_eq($sformatf("cnt_thr%0d_v%b", t, v), int'(cnt_t[t]), int'(exp.cnt));
        check_eq($sformatf("all_thr%0d_v%b", t, v), int'(all_t[t]), int'(exp.all_one));
        check_eq($sformatf("none_thr%0d_v%b", t, v), int'(none_t[t]), int'(exp.none_one));
      end
    end
    if (r) sampled = 1'b0;
    else if (e) sampled = 1'b1;
    if (sampled) begin
      for (int t = 0; t < 5; t++) begin
        check_eq($sformatf("inv_s_thr%0d", t), int'(s_t[t]), int'(int'(cnt_t[t]) >= t));
        check_eq($sformatf("inv_all_thr%0d", t), int'(all_t[t]), int'(cnt_t[t] == 3'd4));
        check_eq($sformatf("inv_none_thr%0d", t), int'(none_t[t]), int'(cnt_t[t] == 3'd0));
      end
    end
  endtask

  initial begin
    logic [3:0] singles [4];
    logic [3:0] pairs   [4];
    logic [3:0] triples [3];
    singles = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    pairs   = '{4'b1100, 4'b1010, 4'b1001, 4'b0011};
    triples = '{4'b1110, 4'b0111, 4'b1011};
    model = '0;

    // Reset with all inputs high and enable set, then release.
    step(1'b1, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);
    step(1'b0, 1'b1, 4'b1111);

    // Single, pair, triple and all-high patterns.
    step(1'b0, 1'b1, 4'b0000);
    foreach (singles[i]) step(1'b0, 1'b1, singles[i]);
    foreach (pairs[i])   step(1'b0, 1'b1, pairs[i]);
    foreach (triples[i]) step(1'b0, 1'b1, triples[i]);
    step(1'b0, 1'b1, 4'b1111);

    // Enable hold, then resume.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0000);

    // Exhaustive sweep of all 16 combinations (all thresholds in parallel).
    for (int v = 0; v < 16; v++) step(1'b0, 1'b1, 4'(v));

    // Mid-operation reset with enable low, then first sample after release.
    step(1'b0, 1'b1, 4'b1111);
    step(1'b1, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 4'b1101);
    step(1'b0, 1'b1, 4'b1101);

    // Random traffic with occasional holds and resets.
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end

endmodule
